// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes and register layouts.
package cp0_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [4:0] BADVADDR = 5'd8;
    localparam logic [4:0] COUNT    = 5'd9;
    localparam logic [4:0] COMPARE  = 5'd11;
    localparam logic [4:0] STATUS   = 5'd12;
    localparam logic [4:0] CAUSE    = 5'd13;
    localparam logic [4:0] EPC      = 5'd14;
    localparam logic [4:0] PRID     = 5'd15;

    typedef enum logic [4:0] {
        INT  = 5'd0,
        ADEL = 5'd4,
        ADES = 5'd5,
        SYS  = 5'd8,
        BP   = 5'd9,
        RI   = 5'd10,
        OV   = 5'd12
    } exc_code_t;

    typedef struct packed {
        logic [8:0] rsvd31_23;
        logic       bev;
        logic [5:0] rsvd21_16;
        logic [7:0] im;
        logic [5:0] rsvd7_2;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] rsvd29_16;
        logic [7:0]  ip;
        logic        rsvd7;
        logic [4:0]  exc_code;
        logic [1:0]  rsvd1_0;
    } cause_t;

    localparam status_t STATUS_RST = status_t'(32'h0040_0000);

    // Restart PC: a delay-slot instruction resumes at its branch.
    function automatic logic [XLEN-1:0] epc_of(input logic [XLEN-1:0] pc, input logic bd);
        return bd ? pc - XLEN'(4) : pc;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: prescaled Count, Compare and the sticky timer interrupt.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_count_we,
    input  logic            i_compare_we,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_count,
    output logic [XLEN-1:0] o_compare,
    output logic            o_ti
);

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0]   r_presc;
    logic [XLEN-1:0] r_count;
    logic [XLEN-1:0] r_compare;
    logic            r_upd;
    logic            r_ti;
    logic            w_tick;

    assign w_tick = (r_presc == PW'(COUNT_DIV - 1));

    // TI fires only when Count advances onto Compare, so Count==Compare at reset is not a hit.
    always_ff @(posedge clk or negedge resetn) begin : p_timer
        if (!resetn) begin
            r_presc   <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_upd     <= 1'b0;
            r_ti      <= 1'b0;
        end else begin
            if (i_count_we) begin
                r_count <= i_wdata;
                r_presc <= '0;
            end else if (w_tick) begin
                r_count <= r_count + XLEN'(1);
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            r_upd <= w_tick & ~i_count_we;
            if (i_compare_we) begin
                r_compare <= i_wdata;
                r_ti      <= 1'b0;
            end else if (r_upd && (r_count == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_ctrl.sv
// Commit-stage CP0: interrupt sync, masked mtc0, trap/ERET priority, flush/redirect, mfc0 mux.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int unsigned N_HW_INT    = 6,
    parameter int unsigned COUNT_DIV   = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] EXC_VEC     = 32'hbfc00380,
    parameter logic [31:0] PRID        = 32'h00004220
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [N_HW_INT-1:0] ext_int,
    input  logic [4:0]          ra,
    output logic [XLEN-1:0]     rdata,
    input  logic                we,
    input  logic [4:0]          wa,
    input  logic [XLEN-1:0]     wdata,
    input  logic                commit_ok,
    input  logic                exc_valid,
    input  exc_code_t           exc_code,
    input  logic [XLEN-1:0]     exc_pc,
    input  logic                exc_bd,
    input  logic [XLEN-1:0]     exc_badv,
    input  logic                eret,
    output logic                flush,
    output logic [XLEN-1:0]     redirect_pc,
    output logic                timer_int
);

    status_t             r_status;
    logic                r_bd;
    logic [4:0]          r_exc_code;
    logic [1:0]          r_ip_sw;
    logic [N_HW_INT-1:0] r_ip_hw;
    logic [XLEN-1:0]     r_epc;
    logic [XLEN-1:0]     r_badv;

    logic [N_HW_INT-1:0] w_ext_sync;
    logic [5:0]          w_ip_hw6;
    logic [7:0]          w_ip;
    cause_t              w_cause;
    logic [XLEN-1:0]     w_count;
    logic [XLEN-1:0]     w_compare;
    logic                w_ti;
    logic                w_int_take;
    logic                w_exc_take;
    logic                w_eret_take;
    logic                w_trap;
    logic                w_we;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_ext_sync = ext_int;
        end else begin : g_sync
            logic [N_HW_INT-1:0] r_sync [SYNC_STAGES];
            always_ff @(posedge clk or negedge resetn) begin : p_sync
                if (!resetn) begin
                    for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
                end else begin
                    r_sync[0] <= ext_int;
                    for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
                end
            end
            assign w_ext_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Top hardware line shares IP[7] with the timer; narrower configs leave it to TI alone.
    assign w_ip_hw6 = 6'(r_ip_hw);
    assign w_ip     = {w_ti | w_ip_hw6[5], w_ip_hw6[4:0], r_ip_sw};

    always_comb begin : p_cause
        w_cause          = '0;
        w_cause.bd       = r_bd;
        w_cause.ti       = w_ti;
        w_cause.ip       = w_ip;
        w_cause.exc_code = r_exc_code;
    end

    assign w_int_take  = commit_ok & r_status.ie & ~r_status.exl & (|(w_ip & r_status.im));
    assign w_exc_take  = ~w_int_take & exc_valid;
    assign w_eret_take = ~w_int_take & ~exc_valid & eret;
    assign w_trap      = w_int_take | w_exc_take;
    assign w_we        = we & ~w_trap;

    assign flush       = w_trap | w_eret_take;
    assign redirect_pc = w_eret_take ? r_epc : EXC_VEC;
    assign timer_int   = w_ti;

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .i_count_we   (w_we && (wa == COUNT)),
        .i_compare_we (w_we && (wa == COMPARE)),
        .i_wdata      (wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    // mtc0 first, then trap/ERET side effects so EXL updates take precedence.
    always_ff @(posedge clk or negedge resetn) begin : p_regs
        if (!resetn) begin
            r_status   <= STATUS_RST;
            r_bd       <= 1'b0;
            r_exc_code <= '0;
            r_ip_sw    <= '0;
            r_ip_hw    <= '0;
            r_epc      <= '0;
            r_badv     <= '0;
        end else begin
            r_ip_hw <= w_ext_sync;
            if (w_we) begin
                case (wa)
                    STATUS: begin
                        r_status.im  <= wdata[15:8];
                        r_status.exl <= wdata[1];
                        r_status.ie  <= wdata[0];
                    end
                    CAUSE:   r_ip_sw <= wdata[9:8];
                    EPC:     r_epc   <= wdata;
                    default: ;
                endcase
            end
            if (w_trap) begin
                r_exc_code <= w_int_take ? 5'(INT) : 5'(exc_code);
                if (!r_status.exl) begin
                    r_epc <= epc_of(exc_pc, exc_bd);
                    r_bd  <= exc_bd;
                end
                r_status.exl <= 1'b1;
                if (w_exc_take && (exc_code == ADEL || exc_code == ADES)) r_badv <= exc_badv;
            end else if (w_eret_take) begin
                r_status.exl <= 1'b0;
            end
        end
    end

    always_comb begin : p_rdata
        rdata = '0;
        case (ra)
            BADVADDR:       rdata = r_badv;
            COUNT:          rdata = w_count;
            COMPARE:        rdata = w_compare;
            STATUS:         rdata = r_status;
            CAUSE:          rdata = w_cause;
            EPC:            rdata = r_epc;
            cp0_pkg::PRID:  rdata = PRID;
            default:        rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios plus randomized mtc0/mfc0 against a register model.
module tb_cp0_ctrl;
    import cp0_pkg::*;

    localparam int unsigned N_HW_INT    = 6;
    localparam int unsigned COUNT_DIV   = 2;
    localparam int unsigned SYNC_STAGES = 2;
    localparam logic [31:0] EXC_VEC_V   = 32'hbfc00380;
    localparam logic [31:0] PRID_V      = 32'h00004220;

    logic                clk;
    logic                resetn;
    logic [N_HW_INT-1:0] ext_int;
    logic [4:0]          ra;
    logic [31:0]         rdata;
    logic                we;
    logic [4:0]          wa;
    logic [31:0]         wdata;
    logic                commit_ok;
    logic                exc_valid;
    exc_code_t           exc_code;
    logic [31:0]         exc_pc;
    logic                exc_bd;
    logic [31:0]         exc_badv;
    logic                eret;
    logic                flush;
    logic [31:0]         redirect_pc;
    logic                timer_int;

    cp0_ctrl #(
        .N_HW_INT(N_HW_INT), .COUNT_DIV(COUNT_DIV), .SYNC_STAGES(SYNC_STAGES),
        .EXC_VEC(EXC_VEC_V), .PRID(PRID_V)
    ) dut (
        .clk(clk), .resetn(resetn), .ext_int(ext_int), .ra(ra), .rdata(rdata),
        .we(we), .wa(wa), .wdata(wdata), .commit_ok(commit_ok), .exc_valid(exc_valid),
        .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badv(exc_badv),
        .eret(eret), .flush(flush), .redirect_pc(redirect_pc), .timer_int(timer_int)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edges    = 0;

    // Architectural model for the randomized phase
    logic [31:0] m_status, m_cause, m_epc, m_badv, m_compare, m_cnt_base;
    int          m_cnt_edge;

    task automatic step();
        @(negedge clk);
        edges++;
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wdata = '0; commit_ok = 1'b0; exc_valid = 1'b0;
        exc_code = INT; exc_pc = '0; exc_bd = 1'b0; exc_badv = '0; eret = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] idx, input logic [31:0] d);
        we = 1'b1; wa = idx; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] idx, output logic [31:0] v);
        ra = idx;
        #1;
        v = rdata;
    endtask

    task automatic do_reset();
        idle();
        ext_int = '0;
        ra = '0;
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        edges = 0;
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] idx);
        case (idx)
            BADVADDR:      return m_badv;
            COUNT:         return m_cnt_base + 32'((edges - m_cnt_edge) / COUNT_DIV);
            COMPARE:       return m_compare;
            STATUS:        return m_status;
            CAUSE:         return m_cause;
            EPC:           return m_epc;
            cp0_pkg::PRID: return PRID_V;
            default:       return 32'h0;
        endcase
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        rd(STATUS, v); n_checks++;
        if (v !== 32'h00400000) begin n_errors++; $display("FAIL reset_status got %h want %h", v, 32'h00400000); end
        rd(CAUSE, v); n_checks++;
        if (v !== 32'h0) begin n_errors++; $display("FAIL reset_cause got %h want %h", v, 32'h0); end
        rd(EPC, v); n_checks++;
        if (v !== 32'h0) begin n_errors++; $display("FAIL reset_epc got %h want %h", v, 32'h0); end
        rd(cp0_pkg::PRID, v); n_checks++;
        if (v !== PRID_V) begin n_errors++; $display("FAIL reset_prid got %h want %h", v, PRID_V); end
        n_checks++;
        if (flush !== 1'b0) begin n_errors++; $display("FAIL reset_flush got %b want 0", flush); end
        n_checks++;
        if (redirect_pc !== EXC_VEC_V) begin n_errors++; $display("FAIL reset_redirect got %h want %h", redirect_pc, EXC_VEC_V); end
        n_checks++;
        if (timer_int !== 1'b0) begin n_errors++; $display("FAIL reset_timer_int got %b want 0", timer_int); end
    endtask

    task automatic test_timer();
        logic [31:0] v;
        int rise = -1;
        mtc0(COUNT, 32'd0);
        mtc0(COMPARE, 32'd5);
        n_checks++;
        if (timer_int !== 1'b0) begin n_errors++; $display("FAIL timer_early got %b want 0", timer_int); end
        // Count reaches 5 after 10 cycles of COUNT_DIV=2; edge index counted from the Count write
        for (int k = 2; k <= 20 && rise < 0; k++) begin
            step();
            if (timer_int === 1'b1) rise = k;
        end
        n_checks++;
        if (rise < 10 || rise > 11) begin n_errors++; $display("FAIL timer_rise got cycle %0d want 10..11", rise); end
        rd(CAUSE, v); n_checks++;
        if (v[30] !== 1'b1) begin n_errors++; $display("FAIL timer_cause_ti got %b want 1", v[30]); end
        mtc0(COMPARE, 32'd9);
        n_checks++;
        if (timer_int !== 1'b0) begin n_errors++; $display("FAIL timer_clear got %b want 0", timer_int); end
    endtask

    task automatic test_interrupt();
        logic [31:0] v;
        int hit = -1;
        mtc0(STATUS, 32'h0000_0401);
        ext_int = N_HW_INT'(1);
        commit_ok = 1'b1;
        exc_pc = 32'h80000100;
        #1;
        n_checks++;
        if (flush !== 1'b0) begin n_errors++; $display("FAIL int_flush_early got %b want 0", flush); end
        for (int k = 1; k <= 10 && hit < 0; k++) begin
            step();
            #1;
            if (flush === 1'b1) hit = k;
        end
        n_checks++;
        if (hit != SYNC_STAGES + 1) begin n_errors++; $display("FAIL int_latency got %0d want %0d", hit, SYNC_STAGES + 1); end
        n_checks++;
        if (redirect_pc !== EXC_VEC_V) begin n_errors++; $display("FAIL int_redirect got %h want %h", redirect_pc, EXC_VEC_V); end
        step();
        #1;
        n_checks++;
        if (flush !== 1'b0) begin n_errors++; $display("FAIL int_masked_by_exl got %b want 0", flush); end
        commit_ok = 1'b0;
        rd(CAUSE, v); n_checks++;
        if (v[6:2] !== 5'd0) begin n_errors++; $display("FAIL int_exccode got %0d want 0", v[6:2]); end
        rd(EPC, v); n_checks++;
        if (v !== 32'h80000100) begin n_errors++; $display("FAIL int_epc got %h want %h", v, 32'h80000100); end
        rd(STATUS, v); n_checks++;
        if (v[1] !== 1'b1) begin n_errors++; $display("FAIL int_exl got %b want 1", v[1]); end
        ext_int = '0;
        idle();
    endtask

    task automatic test_nested_eret();
        logic [31:0] v;
        exc_valid = 1'b1; exc_code = SYS; exc_pc = 32'h80002000;
        #1;
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== EXC_VEC_V) begin
            n_errors++; $display("FAIL nested_flush got %b/%h want 1/%h", flush, redirect_pc, EXC_VEC_V);
        end
        step();
        idle();
        rd(EPC, v); n_checks++;
        if (v !== 32'h80000100) begin n_errors++; $display("FAIL nested_epc_held got %h want %h", v, 32'h80000100); end
        rd(CAUSE, v); n_checks++;
        if (v[6:2] !== 5'd8) begin n_errors++; $display("FAIL nested_exccode got %0d want 8", v[6:2]); end
        // ERET with a same-cycle EPC write: redirect still uses the old EPC
        eret = 1'b1; we = 1'b1; wa = EPC; wdata = 32'h80003000;
        #1;
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h80000100) begin
            n_errors++; $display("FAIL eret_redirect got %b/%h want 1/%h", flush, redirect_pc, 32'h80000100);
        end
        step();
        idle();
        rd(STATUS, v); n_checks++;
        if (v[1] !== 1'b0) begin n_errors++; $display("FAIL eret_exl got %b want 0", v[1]); end
        rd(EPC, v); n_checks++;
        if (v !== 32'h80003000) begin n_errors++; $display("FAIL eret_epc_write got %h want %h", v, 32'h80003000); end
    endtask

    task automatic test_delay_slot();
        logic [31:0] v;
        exc_valid = 1'b1; exc_code = ADEL; exc_pc = 32'h80001004; exc_bd = 1'b1; exc_badv = 32'h3;
        step();
        idle();
        rd(EPC, v); n_checks++;
        if (v !== 32'h80001000) begin n_errors++; $display("FAIL ds_epc got %h want %h", v, 32'h80001000); end
        rd(CAUSE, v); n_checks++;
        if (v[31] !== 1'b1 || v[6:2] !== 5'd4) begin
            n_errors++; $display("FAIL ds_cause got bd=%b code=%0d want bd=1 code=4", v[31], v[6:2]);
        end
        rd(BADVADDR, v); n_checks++;
        if (v !== 32'h3) begin n_errors++; $display("FAIL ds_badvaddr got %h want %h", v, 32'h3); end
        eret = 1'b1;
        step();
        idle();
    endtask

    task automatic test_priority();
        logic [31:0] v;
        mtc0(COMPARE, 32'h00C0FFEE);
        ext_int = N_HW_INT'(1);
        for (int k = 0; k < 4; k++) step();
        commit_ok = 1'b1; exc_valid = 1'b1; exc_code = RI; eret = 1'b1;
        exc_pc = 32'h80004000; we = 1'b1; wa = COMPARE; wdata = 32'h12345678;
        #1;
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== EXC_VEC_V) begin
            n_errors++; $display("FAIL prio_flush got %b/%h want 1/%h", flush, redirect_pc, EXC_VEC_V);
        end
        step();
        idle();
        ext_int = '0;
        rd(CAUSE, v); n_checks++;
        if (v[6:2] !== 5'd0) begin n_errors++; $display("FAIL prio_exccode got %0d want 0", v[6:2]); end
        rd(COMPARE, v); n_checks++;
        if (v !== 32'h00C0FFEE) begin n_errors++; $display("FAIL prio_compare got %h want %h", v, 32'h00C0FFEE); end
        rd(EPC, v); n_checks++;
        if (v !== 32'h80004000) begin n_errors++; $display("FAIL prio_epc got %h want %h", v, 32'h80004000); end
        rd(STATUS, v); n_checks++;
        if (v[1] !== 1'b1) begin n_errors++; $display("FAIL prio_eret_dropped got exl=%b want 1", v[1]); end
        eret = 1'b1;
        step();
        idle();
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        mtc0(EPC, 32'h11112222);
        mtc0(STATUS, 32'h0000FF03);
        #2;
        resetn = 1'b0;
        rd(STATUS, v); n_checks++;
        if (v !== 32'h00400000) begin n_errors++; $display("FAIL async_status got %h want %h", v, 32'h00400000); end
        rd(EPC, v); n_checks++;
        if (v !== 32'h0) begin n_errors++; $display("FAIL async_epc got %h want %h", v, 32'h0); end
        step();
        resetn = 1'b1;
        edges = 0;
    endtask

    task automatic test_random_regs();
        logic [4:0]  idx_tab [8];
        logic [4:0]  idx;
        logic [31:0] d, v, exp;
        idx_tab = '{BADVADDR, COUNT, COMPARE, STATUS, CAUSE, EPC, cp0_pkg::PRID, 5'd0};
        do_reset();
        m_status = 32'h00400000; m_cause = 32'h0; m_epc = 32'h0; m_badv = 32'h0;
        m_compare = 32'h0; m_cnt_base = 32'h0; m_cnt_edge = 0;
        for (int it = 0; it < 40; it++) begin
            int r = $urandom_range(0, 7);
            idx = (r == 7) ? 5'($urandom_range(0, 31)) : idx_tab[r];
            d = $urandom;
            we = 1'b1; wa = idx; wdata = d;
            rd(idx, v);
            exp = model_rd(idx);
            n_checks++;
            if (v !== exp) begin n_errors++; $display("FAIL rnd_nobypass idx=%0d got %h want %h", idx, v, exp); end
            step();
            we = 1'b0;
            case (idx)
                COUNT:   begin m_cnt_base = d; m_cnt_edge = edges; end
                COMPARE: m_compare = d;
                STATUS:  m_status = 32'h00400000 | (d & 32'h0000FF03);
                CAUSE:   m_cause = d & 32'h00000300;
                EPC:     m_epc = d;
                default: ;
            endcase
            for (int w = $urandom_range(0, 3); w > 0; w--) step();
            rd(idx, v);
            exp = model_rd(idx);
            n_checks++;
            if (v !== exp) begin n_errors++; $display("FAIL rnd_read idx=%0d got %h want %h", idx, v, exp); end
            rd(COUNT, v);
            exp = model_rd(COUNT);
            n_checks++;
            if (v !== exp) begin n_errors++; $display("FAIL rnd_count got %h want %h", v, exp); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        ext_int = '0;
        ra = '0;
        idle();
        test_reset();
        test_timer();
        test_interrupt();
        test_nested_eret();
        test_delay_slot();
        test_priority();
        test_async_reset();
        test_random_regs();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
